// File: rtl/riscv_pkg.sv
// Shared constants and fetch FSM state encoding for the RV32 front end.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that catches a fetch response
// arriving while the IF/ID output slot is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            wr_i,
  input  logic [XLEN-1:0] wr_instr_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            rd_i,
  output logic            full_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            full_q,  full_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  // A write in the same cycle as a read refills the entry just drained.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (wr_i) begin
      full_d  = 1'b1;
      instr_d = wr_instr_i;
      pc_d    = wr_pc_i;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch to instruction memory and presents {instr, pc, pc+4, valid} to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_incr_o,
  output logic        valid_o
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            skid_full, skid_wr, skid_rd, skid_flush;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            take_resp, out_free;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc_i & ~32'h3;
  assign take_resp        = (state_q == ST_WAIT) && imem_rvalid_i && !kill_q;
  assign out_free         = !valid_q || !stall_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    skid_wr    = 1'b0;
    skid_rd    = 1'b0;
    skid_flush = 1'b0;

    if (redirect_i) begin
      pc_d       = redirect_aligned;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_flush = 1'b1;
      case (state_q)
        ST_REQ: begin
          if (imem_gnt_i) begin
            fetch_pc_d = pc_q;
            kill_d     = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            kill_d = kill_q && !imem_rvalid_i;
          end
        end
        ST_WAIT: begin
          // A response landing with the redirect is the wrong-path one itself.
          kill_d = !imem_rvalid_i;
          if (imem_rvalid_i) state_d = ST_REQ;
        end
        default: kill_d = kill_q && !imem_rvalid_i;
      endcase
    end else begin
      if (kill_q && imem_rvalid_i) kill_d = 1'b0;

      case (state_q)
        ST_IDLE: if (!skid_full) state_d = ST_REQ;
        ST_REQ: begin
          if (imem_gnt_i) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_WAIT;
          end
        end
        default: ;
      endcase

      if (out_free) begin
        if (skid_full) begin
          valid_d  = 1'b1;
          instr_d  = skid_instr;
          out_pc_d = skid_pc;
          skid_rd  = 1'b1;
          skid_wr  = take_resp;
        end else if (take_resp) begin
          valid_d  = 1'b1;
          instr_d  = imem_rdata_i;
          out_pc_d = fetch_pc_q;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end else begin
        skid_wr = take_resp;
      end

      // Park in IDLE while the skid holds data so no new request is issued.
      if (state_q == ST_WAIT && imem_rvalid_i)
        state_d = (skid_wr || (skid_full && !skid_rd)) ? ST_IDLE : ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      kill_q     <= (kill_q || state_q == ST_WAIT) && !imem_rvalid_i;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      out_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (skid_flush),
    .wr_i       (skid_wr),
    .wr_instr_i (imem_rdata_i),
    .wr_pc_i    (fetch_pc_q),
    .rd_i       (skid_rd),
    .full_o     (skid_full),
    .instr_o    (skid_instr),
    .pc_o       (skid_pc)
  );

  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = out_pc_q;
  assign pc_incr_o   = out_pc_q + 32'd4;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory handshake driven cycle by cycle with
// hand-computed expectations for every observable output.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_incr_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_incr_o     (pc_incr_o),
    .valid_o       (valid_o)
  );

  // Drive one cycle of inputs, take the rising edge, then settle for sampling.
  task automatic applyStimulus(input logic r, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic g,
                               input logic rv, input logic [31:0] rdat);
    rst           = r;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdat;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // pc_o/pc_incr_o are only meaningful while valid_o is high.
  task automatic checkState(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] instr,
                            input logic [31:0] pc);
    checkOutput({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, req});
    checkOutput({tag, ".addr"},  imem_addr_o, addr);
    checkOutput({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
    checkOutput({tag, ".instr"}, instr_o, vld ? instr : NOP);
    if (vld) begin
      checkOutput({tag, ".pc"},   pc_o, pc);
      checkOutput({tag, ".incr"}, pc_incr_o, pc + 32'd4);
    end
  endtask

  initial begin
    // Reset values
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkState("reset", 0, 32'h0, 0, NOP, 0);
    checkOutput("reset.pc",   pc_o, 32'h0);
    checkOutput("reset.incr", pc_incr_o, 32'h4);

    // First fetch with zero-wait memory
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("t1_req", 1, 32'h0, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t1_wait", 0, 32'h4, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0050_0093);
    checkState("t1_out", 1, 32'h4, 1, 32'h0050_0093, 32'h0);

    // Stall with a response captured in the skid
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    checkState("t2_gnt", 0, 32'h8, 1, 32'h0050_0093, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h00A0_0113);
    checkState("t2_skid", 0, 32'h8, 1, 32'h0050_0093, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("t2_hold", 0, 32'h8, 1, 32'h0050_0093, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("t2_drain", 0, 32'h8, 1, 32'h00A0_0113, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("t2_req8", 1, 32'h8, 0, NOP, 0);

    // Redirect while waiting on pc 8
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t3_wait8", 0, 32'hC, 0, NOP, 0);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 0);
    checkState("t3_redir", 0, 32'h100, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkState("t3_killed", 1, 32'h100, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t3_wait100", 0, 32'h104, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0010_0193);
    checkState("t3_out", 1, 32'h104, 1, 32'h0010_0193, 32'h100);

    // Delayed grant holds request and address
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkState($sformatf("t4_nognt%0d", i), 1, 32'h104, 0, NOP, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t4_gnt", 0, 32'h108, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0020_8233);
    checkState("t4_out", 1, 32'h108, 1, 32'h0020_8233, 32'h104);

    // Reset during WAIT; stale response right after reset is dropped
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t5_wait", 0, 32'h10C, 0, NOP, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkState("t5_rst", 0, 32'h0, 0, NOP, 0);
    checkOutput("t5_rst.pc", pc_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    checkState("t5_stale", 1, 32'h0, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t5_wait0", 0, 32'h4, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0050_0093);
    checkState("t5_refetch", 1, 32'h4, 1, 32'h0050_0093, 32'h0);

    // Misaligned redirect under stall, then PC wrap at the top of memory
    applyStimulus(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    checkState("t6_redir", 1, 32'hFFFF_FFFC, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkState("t6_wrap_addr", 0, 32'h0, 0, NOP, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5013);
    checkState("t6_out", 1, 32'h0, 1, 32'h1234_5013, 32'hFFFF_FFFC);
    checkOutput("t6_incr_zero", pc_incr_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
